// File: rtl/clk_diag_decoder.sv
// CLK board diagnostic function decoder: strobe sync, register loads, EBOX clock-enable FSM.
// Optional burst support (003/042/043 and BURST state) is built only when CLK_DIAG_BURST_EN is defined.
module clk_diag_decoder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        CROBAR,
   input  logic        diagStrobe,
   input  logic [0:6]  ds,
   input  logic [0:35] data,
   output logic        clkEn,
   output logic        mrReset,
   output logic [0:1]  sourceSel,
   output logic [0:1]  rateSel,
   output logic [0:3]  parChk,
   output logic [0:3]  mboxCtl,
   output logic [0:10] crmDiagAdr,
   output logic [0:7]  burstCnt,
   output logic        funcDone,
   output logic        funcBad
);

   typedef enum logic [1:0] {
      ST_STOPPED,
      ST_RUNNING,
      ST_STEP
`ifdef CLK_DIAG_BURST_EN
      , ST_BURST
`endif
   } state_e;

   // Top bit of the chain is the previous synchronized level, used for edge detect.
   logic [SYNC_STAGES:0] sync_q, sync_d;
   logic                 go_q, go_d;
   state_e               state_q, state_d;
   logic                 mr_reset_q, mr_reset_d;
   logic [0:1]           source_sel_q, source_sel_d;
   logic [0:1]           rate_sel_q, rate_sel_d;
   logic [0:3]           par_chk_q, par_chk_d;
   logic [0:3]           mbox_ctl_q, mbox_ctl_d;
   logic [0:10]          crm_adr_q, crm_adr_d;
   logic                 func_done_q, func_done_d;
   logic                 func_bad_q, func_bad_d;
`ifdef CLK_DIAG_BURST_EN
   logic [0:7]           burst_cnt_q, burst_cnt_d;
`endif

   logic unused_data;
   assign unused_data = ^data[0:29];

   always_comb begin
      sync_d        = {sync_q[SYNC_STAGES-1:0], diagStrobe};
      go_d          = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
      state_d       = (state_q == ST_STEP) ? ST_STOPPED : state_q;
      mr_reset_d    = mr_reset_q;
      source_sel_d  = source_sel_q;
      rate_sel_d    = rate_sel_q;
      par_chk_d     = par_chk_q;
      mbox_ctl_d    = mbox_ctl_q;
      crm_adr_d     = crm_adr_q;
      func_done_d   = 1'b0;
      func_bad_d    = 1'b0;
`ifdef CLK_DIAG_BURST_EN
      burst_cnt_d   = burst_cnt_q;
      if (state_q == ST_BURST && burst_cnt_q != 8'd0)
         burst_cnt_d = burst_cnt_q - 8'd1;
`endif
      if (go_q && !ds[0]) begin
         func_done_d = 1'b1;
         case (ds)
            7'o000: begin
               state_d = ST_STOPPED;
`ifdef CLK_DIAG_BURST_EN
               burst_cnt_d = burst_cnt_q;
`endif
            end
            7'o001: begin
               state_d = ST_RUNNING;
`ifdef CLK_DIAG_BURST_EN
               burst_cnt_d = burst_cnt_q;
`endif
            end
            7'o002, 7'o004: if (state_q == ST_STOPPED) state_d = ST_STEP;
`ifdef CLK_DIAG_BURST_EN
            7'o003: if (state_q == ST_STOPPED && burst_cnt_q != 8'd0) state_d = ST_BURST;
            // Loads replace the undecremented count, so a load beats the decrement.
            7'o042: burst_cnt_d = {burst_cnt_q[0:3], data[32:35]};
            7'o043: burst_cnt_d = {data[32:35], burst_cnt_q[4:7]};
`endif
            7'o006: mr_reset_d = 1'b0;
            7'o007: mr_reset_d = 1'b1;
            7'o044: begin
               source_sel_d = data[32:33];
               rate_sel_d   = data[34:35];
            end
            7'o046: par_chk_d  = data[32:35];
            7'o047: mbox_ctl_d = data[32:35];
            7'o051: crm_adr_d  = {crm_adr_q[0:4], data[30:35]};
            7'o052: crm_adr_d  = {data[31:35], crm_adr_q[5:10]};
            default: begin
               func_done_d = 1'b0;
               func_bad_d  = 1'b1;
            end
         endcase
      end
`ifdef CLK_DIAG_BURST_EN
      // The cycle showing count 1 is the last enabled one; a load of 0 also ends the burst.
      if (state_d == ST_BURST && burst_cnt_d == 8'd0)
         state_d = ST_STOPPED;
`endif
   end

   always_ff @(posedge clk or posedge CROBAR) begin
      if (CROBAR) begin
         sync_q       <= '0;
         go_q         <= 1'b0;
         state_q      <= ST_STOPPED;
         mr_reset_q   <= 1'b1;
         source_sel_q <= '0;
         rate_sel_q   <= '0;
         par_chk_q    <= '0;
         mbox_ctl_q   <= '0;
         crm_adr_q    <= '0;
         func_done_q  <= 1'b0;
         func_bad_q   <= 1'b0;
`ifdef CLK_DIAG_BURST_EN
         burst_cnt_q  <= '0;
`endif
      end else begin
         sync_q       <= sync_d;
         go_q         <= go_d;
         state_q      <= state_d;
         mr_reset_q   <= mr_reset_d;
         source_sel_q <= source_sel_d;
         rate_sel_q   <= rate_sel_d;
         par_chk_q    <= par_chk_d;
         mbox_ctl_q   <= mbox_ctl_d;
         crm_adr_q    <= crm_adr_d;
         func_done_q  <= func_done_d;
         func_bad_q   <= func_bad_d;
`ifdef CLK_DIAG_BURST_EN
         burst_cnt_q  <= burst_cnt_d;
`endif
      end
   end

   assign clkEn      = (state_q != ST_STOPPED);
   assign mrReset    = mr_reset_q;
   assign sourceSel  = source_sel_q;
   assign rateSel    = rate_sel_q;
   assign parChk     = par_chk_q;
   assign mboxCtl    = mbox_ctl_q;
   assign crmDiagAdr = crm_adr_q;
   assign funcDone   = func_done_q;
   assign funcBad    = func_bad_q;
`ifdef CLK_DIAG_BURST_EN
   assign burstCnt   = burst_cnt_q;
`else
   assign burstCnt   = '0;
`endif

endmodule

// File: tb/tb_clk_diag_decoder.sv
// Randomized bench for clk_diag_decoder against a function-level model of the CLK diag registers.
module tb_clk_diag_decoder;
   localparam int SS = 2;
`ifdef CLK_DIAG_BURST_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        CROBAR = 1'b1;
   logic        diagStrobe = 1'b0;
   logic [0:6]  ds = '0;
   logic [0:35] data = '0;
   logic        clkEn, mrReset, funcDone, funcBad;
   logic [0:1]  sourceSel, rateSel;
   logic [0:3]  parChk, mboxCtl;
   logic [0:10] crmDiagAdr;
   logic [0:7]  burstCnt;

   always #5 clk = ~clk;

   clk_diag_decoder #(.SYNC_STAGES(SS)) dut (
      .clk(clk), .CROBAR(CROBAR), .diagStrobe(diagStrobe), .ds(ds), .data(data),
      .clkEn(clkEn), .mrReset(mrReset), .sourceSel(sourceSel), .rateSel(rateSel),
      .parChk(parChk), .mboxCtl(mboxCtl), .crmDiagAdr(crmDiagAdr), .burstCnt(burstCnt),
      .funcDone(funcDone), .funcBad(funcBad)
   );

   int checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Monitor samples 1 time unit after each rising edge.
   int cyc = 0, en_cnt = 0, done_cnt = 0, bad_cnt = 0, done_at = 0;
   always @(posedge clk) begin
      #1;
      cyc++;
      if (clkEn) en_cnt++;
      if (funcDone) begin done_cnt++; done_at = cyc; end
      if (funcBad) bad_cnt++;
   end

   // Model: only settled state matters between transactions (running or stopped).
   bit m_run;
   int m_mr, m_src, m_rate, m_par, m_mbox, m_crm, m_bc;

   task automatic model_reset();
      m_run = 0; m_mr = 1; m_src = 0; m_rate = 0; m_par = 0; m_mbox = 0; m_crm = 0; m_bc = 0;
   endtask

   function automatic bit decoded(input int c);
      case (c)
         0, 1, 2, 4, 6, 7, 'o44, 'o46, 'o47, 'o51, 'o52: return 1'b1;
         3, 'o42, 'o43: return BURST_EN;
         default: return 1'b0;
      endcase
   endfunction

   int d_en, d_done, d_bad, w_start;

   task automatic issue(input int code, input logic [0:35] dv, input int hold, input int win);
      int e0, dn0, b0;
      @(negedge clk);
      ds = 7'(code); data = dv; diagStrobe = 1'b1;
      e0 = en_cnt; dn0 = done_cnt; b0 = bad_cnt; w_start = cyc;
      repeat (hold) @(negedge clk);
      diagStrobe = 1'b0;
      repeat (win - hold) @(negedge clk);
      d_en = en_cnt - e0; d_done = done_cnt - dn0; d_bad = bad_cnt - b0;
   endtask

   task automatic tx(input int code, input logic [0:35] dv, input int hold);
      longint v;
      int win, extra, exp_en;
      bit old_run, exp_done, exp_bad;
      v = longint'(dv);
      win = hold + 8 + ((code == 3) ? m_bc : 0);
      issue(code, dv, hold, win);
      old_run = m_run; extra = 0;
      exp_done = (code < 64) && decoded(code);
      exp_bad  = (code < 64) && !decoded(code);
      if (exp_done) begin
         case (code)
            0: m_run = 0;
            1: m_run = 1;
            2, 4: if (!old_run) extra = 1;
            3: if (!old_run && m_bc != 0) begin extra = m_bc; m_bc = 0; end
            6: m_mr = 0;
            7: m_mr = 1;
            'o42: m_bc = (m_bc / 16) * 16 + int'(v % 16);
            'o43: m_bc = int'(v % 16) * 16 + m_bc % 16;
            'o44: begin m_src = int'((v % 16) / 4); m_rate = int'(v % 4); end
            'o46: m_par = int'(v % 16);
            'o47: m_mbox = int'(v % 16);
            'o51: m_crm = (m_crm / 64) * 64 + int'(v % 64);
            'o52: m_crm = int'(v % 32) * 64 + m_crm % 64;
            default: ;
         endcase
      end
      exp_en = (old_run ? SS + 1 : 0) + (m_run ? win - SS - 1 : 0) + extra;
      chk($sformatf("done_%0o", code), 64'(d_done), 64'(exp_done));
      chk($sformatf("bad_%0o", code), 64'(d_bad), 64'(exp_bad));
      if (d_done == 1) chk($sformatf("lat_%0o", code), 64'(done_at - w_start), 64'(SS + 2));
      chk($sformatf("en_cycles_%0o", code), 64'(d_en), 64'(exp_en));
      chk($sformatf("clkEn_%0o", code), 64'(clkEn), 64'(m_run));
      chk($sformatf("regs_%0o", code),
          64'({mrReset, sourceSel, rateSel, parChk, mboxCtl, crmDiagAdr, burstCnt}),
          64'({1'(m_mr), 2'(m_src), 2'(m_rate), 4'(m_par), 4'(m_mbox), 11'(m_crm), 8'(m_bc)}));
   endtask

   int codes [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 'o42, 'o43, 'o44, 'o46, 'o47, 'o51, 'o52, 'o100};

   initial begin
      int k, code;
      logic [0:35] d;
      model_reset();
      repeat (50) @(negedge clk);
      chk("rst_clkEn", 64'(clkEn), 64'(0));
      chk("rst_mrReset", 64'(mrReset), 64'(1));
      chk("rst_regs", 64'({sourceSel, rateSel, parChk, mboxCtl, crmDiagAdr, burstCnt}), 64'(0));
      chk("rst_pulses", 64'({funcDone, funcBad}), 64'(0));
      CROBAR = 1'b0;
      repeat (3) @(negedge clk);

      tx(1, '0, 10);
      tx(0, '0, 10);
      tx('o42, 36'o5, 10);
      tx('o43, 36'o0, 10);
      tx(3, '0, 10);
      tx('o44, 36'o3, 10);
      chk("src_rate", 64'({sourceSel, rateSel}), 64'(3));
      tx('o51, 36'o77, 10);
      tx('o52, 36'o12, 10);
      chk("crm_1277", 64'(crmDiagAdr), 64'(11'o1277));
      tx(2, '0, 20);
      tx(5, '0, 10);
      tx('o100, '0, 10);
      tx(6, '0, 9);
      tx(7, '0, 9);

      // Burst of 20 aborted by 000: count left is 21 minus enabled cycles seen.
      tx('o42, 36'o4, 10);
      tx('o43, 36'o1, 10);
      issue(3, '0, 8, 12);
      chk("b3_bad", 64'(d_bad), 64'(!BURST_EN));
      k = d_en;
      issue(0, '0, 8, 12);
      k += d_en;
      chk("abort_early", 64'(k > 0 && k < 20), 64'(BURST_EN));
      chk("abort_cnt", 64'(burstCnt), 64'(BURST_EN ? 21 - k : 0));
      chk("abort_clkEn", 64'(clkEn), 64'(0));
      m_run = 0; m_bc = BURST_EN ? 21 - k : 0;

      // Reset on the 3rd cycle of a 10-cycle burst.
      tx('o42, 36'o12, 10);
      tx('o43, 36'o0, 10);
      @(negedge clk);
      ds = 7'o003; diagStrobe = 1'b1;
      repeat (SS + 4) @(posedge clk);
      #1;
      chk("burst_on", 64'(clkEn), 64'(BURST_EN));
      #2 CROBAR = 1'b1;
      #1;
      chk("rst_mid_clkEn", 64'(clkEn), 64'(0));
      chk("rst_mid_cnt", 64'(burstCnt), 64'(0));
      chk("rst_mid_mr", 64'(mrReset), 64'(1));
      @(negedge clk);
      diagStrobe = 1'b0;
      repeat (4) @(negedge clk);
      CROBAR = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) code = int'($urandom_range(0, 127));
         else code = codes[$urandom_range(0, 15)];
         d = {4'($urandom()), 32'($urandom())};
         tx(code, d, int'($urandom_range(8, 20)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
